// File: rtl/fpu_issue_pkg.sv
// fpu_issue_pkg: shared types and constants for the FPU issue sequencer.
//   state_t     - sequencer FSM states
//   F7_*        - funct7 encodings with a dedicated latency
//   LAT_*       - per-op latency in cycles, CNT_W latency counter width
//   op_latency  - funct7 -> latency decode
package fpu_issue_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    WAIT    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [6:0] F7_ADD  = 7'h00;
  localparam logic [6:0] F7_SUB  = 7'h04;
  localparam logic [6:0] F7_MUL  = 7'h08;
  localparam logic [6:0] F7_DIV  = 7'h0C;
  localparam logic [6:0] F7_SQRT = 7'h2C;

  localparam int LAT_ADD     = 3;
  localparam int LAT_MUL     = 4;
  localparam int LAT_DIV     = 12;
  localparam int LAT_SQRT    = 16;
  localparam int LAT_DEFAULT = 1;

  // Must hold max(LAT_*) - 1; also holds LAT_SQRT itself so op_latency fits.
  localparam int CNT_W = 5;

  function automatic logic [CNT_W-1:0] op_latency(input logic [6:0] funct7);
    case (funct7)
      F7_ADD, F7_SUB: op_latency = CNT_W'(LAT_ADD);
      F7_MUL:         op_latency = CNT_W'(LAT_MUL);
      F7_DIV:         op_latency = CNT_W'(LAT_DIV);
      F7_SQRT:        op_latency = CNT_W'(LAT_SQRT);
      default:        op_latency = CNT_W'(LAT_DEFAULT);
    endcase
  endfunction

endpackage

// File: rtl/fpu_issue_lat_timer.sv
// fpu_issue_lat_timer: loadable down-counter used to model op latency.
//   clk_i, rst_i   - clock, synchronous active-high reset
//   load_i         - load load_val_i (wins over dec_i)
//   load_val_i     - value to load
//   dec_i          - decrement by one (saturates at zero)
//   zero_o         - this decrement takes the count to zero
module fpu_issue_lat_timer #(
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // Flag on the decrement that reaches zero so the FSM leaves WAIT in that
  // same cycle; a count already at zero also reports done.
  assign zero_o = dec_i && (cnt_q <= W'(1));

endmodule

// File: rtl/fpu_issue_seq.sv
// fpu_issue_seq: issue sequencer in front of the FPU compute stage.
// Accepts one op, strobes the FPU for one cycle, captures its registered
// result the next cycle, models the op latency, then offers the result on a
// writeback port. One op in flight, no reordering.
//
// Handshakes: a transfer happens on a rising clock edge where valid && ready
// are both high; valid-side data is held stable until that edge. req_ready
// is combinational (IDLE, or DONE mirroring wb_ready) and forced low by
// reset or flush.
//
// Ports:
//   clock, reset            - clock, synchronous active-high reset
//   flush                   - abandon in-flight op, back to IDLE
//   req_*                   - op request (valid/ready), operands, funct, rd tag
//   fpu_*                   - registered operands/funct and one-cycle strobe
//   fpu_r                   - FPU result, valid the cycle after fpu_valid
//   wb_*                    - result writeback (valid/ready), data and tag
//   stat_ops, stat_stall    - only with FPU_ISSUE_STATS_EN defined
//   dbg_state               - current FSM state
module fpu_issue_seq
  import fpu_issue_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [6:0]  req_funct7,
  input  logic [2:0]  req_funct3,
  input  logic        req_rs2b0,
  input  logic [4:0]  req_rd,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [6:0]  fpu_funct7,
  output logic [2:0]  fpu_funct3,
  output logic        fpu_rs2b0,
  output logic        fpu_valid,
  input  logic [31:0] fpu_r,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
`ifdef FPU_ISSUE_STATS_EN
  output logic [31:0] stat_ops,
  output logic [31:0] stat_stall,
`endif
  output state_t      dbg_state
);

  state_t             state_q;
  logic [31:0]        fpu_a_q, fpu_b_q, res_q;
  logic [6:0]         fpu_funct7_q;
  logic [2:0]         fpu_funct3_q;
  logic               fpu_rs2b0_q, fpu_valid_q, wb_valid_q;
  logic [4:0]         rd_q;
  logic [CNT_W-1:0]   lat;
  logic               accept;
  logic               tmr_zero;

  // Latency decode works on the latched funct7, used only in CAPTURE.
  assign lat = op_latency(fpu_funct7_q);

  always_comb begin
    req_ready = 1'b0;
    if (!reset && !flush) begin
      case (state_q)
        IDLE:    req_ready = 1'b1;
        DONE:    req_ready = wb_ready;
        default: req_ready = 1'b0;
      endcase
    end
  end

  assign accept = req_valid && req_ready;

  fpu_issue_lat_timer #(.W(CNT_W)) u_timer (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (state_q == CAPTURE),
    .load_val_i (lat - CNT_W'(1)),
    .dec_i      (state_q == WAIT),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      fpu_a_q      <= '0;
      fpu_b_q      <= '0;
      fpu_funct7_q <= '0;
      fpu_funct3_q <= '0;
      fpu_rs2b0_q  <= 1'b0;
      fpu_valid_q  <= 1'b0;
      wb_valid_q   <= 1'b0;
      res_q        <= '0;
      rd_q         <= '0;
    end else if (flush) begin
      state_q     <= IDLE;
      fpu_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
    end else begin
      fpu_valid_q <= 1'b0;
      case (state_q)
        IDLE:  ;
        ISSUE: state_q <= CAPTURE;
        CAPTURE: begin
          res_q <= fpu_r;
          if (lat > CNT_W'(1)) begin
            state_q <= WAIT;
          end else begin
            state_q    <= DONE;
            wb_valid_q <= 1'b1;
          end
        end
        WAIT: begin
          if (tmr_zero) begin
            state_q    <= DONE;
            wb_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (wb_ready) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
      // Accept is only possible in IDLE or on the DONE handshake, so it
      // overrides the return to IDLE and gives back-to-back issue.
      if (accept) begin
        state_q      <= ISSUE;
        fpu_a_q      <= req_a;
        fpu_b_q      <= req_b;
        fpu_funct7_q <= req_funct7;
        fpu_funct3_q <= req_funct3;
        fpu_rs2b0_q  <= req_rs2b0;
        rd_q         <= req_rd;
        fpu_valid_q  <= 1'b1;
      end
    end
  end

`ifdef FPU_ISSUE_STATS_EN
  logic [31:0] stat_ops_q, stat_stall_q;

  // Cleared by reset only; flush keeps the history.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_ops_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      if (wb_valid_q && wb_ready) stat_ops_q <= stat_ops_q + 32'd1;
      if ((state_q == DONE) && !wb_ready) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_ops   = stat_ops_q;
  assign stat_stall = stat_stall_q;
`endif

  assign fpu_a      = fpu_a_q;
  assign fpu_b      = fpu_b_q;
  assign fpu_funct7 = fpu_funct7_q;
  assign fpu_funct3 = fpu_funct3_q;
  assign fpu_rs2b0  = fpu_rs2b0_q;
  assign fpu_valid  = fpu_valid_q;
  assign wb_valid   = wb_valid_q;
  assign wb_data    = res_q;
  assign wb_rd      = rd_q;
  assign dbg_state  = state_q;

endmodule
